hazard_unit_mc: RTL and testbench

- Parametrised successor to the 5-stage pipeline hazard unit.
- Provides EX-stage forwarding, load-use stalling with a configurable bubble count for slower data memory, and a multi-cycle execute (MUL/DIV) stall handshake with a watchdog.
- Provides branch/jump flush and a saturating stall-cycle performance counter.
- Sits beside the datapath; drives stall/flush enables of the F/D, D/E and E/M pipeline registers and the EX operand muxes.

---
 rtl/hazard_unit_mc_if.sv | 59 +++++
 rtl/hazard_unit_mc.sv | 151 +++++++++++++++
 tb/tb_hazard_unit_mc.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_mc_if.sv
// hazard_unit_mc_if
// Purpose: bundles every datapath-facing signal of the multi-cycle hazard
// unit so the datapath and the hazard unit connect through one port.
// Modports:
//   master - datapath side: drives register addresses, write enables,
//            result/PC selects and the MD handshake; receives the
//            stall/flush/forward controls and status.
//   slave  - hazard unit side: the mirror image of master.
// Signals:
//   Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW  register addresses (ADDR_W)
//   RegWriteM, RegWriteW                  write enables in M and W
//   ResultSrcE (2), PCSrcE (2)            load select / redirect in E
//   mdStartE, mdDone                      multi-cycle execute handshake
//   StallF/D/E, FlushD/E/M                pipeline register controls
//   ForwardAE, ForwardBE (2)              EX operand mux selects
//   mdTimeout                             sticky watchdog flag
//   stallCycles (CNT_W)                   saturating stall counter
interface hazard_unit_mc_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) ();
  logic [ADDR_W-1:0] Rs1D;
  logic [ADDR_W-1:0] Rs2D;
  logic [ADDR_W-1:0] Rs1E;
  logic [ADDR_W-1:0] Rs2E;
  logic [ADDR_W-1:0] RdE;
  logic [ADDR_W-1:0] RdM;
  logic [ADDR_W-1:0] RdW;
  logic              RegWriteM;
  logic              RegWriteW;
  logic [1:0]        ResultSrcE;
  logic [1:0]        PCSrcE;
  logic              mdStartE;
  logic              mdDone;
  logic              StallF;
  logic              StallD;
  logic              StallE;
  logic              FlushD;
  logic              FlushE;
  logic              FlushM;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              mdTimeout;
  logic [CNT_W-1:0]  stallCycles;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, mdStartE, mdDone,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
    input  ForwardAE, ForwardBE, mdTimeout, stallCycles
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, mdStartE, mdDone,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
    output ForwardAE, ForwardBE, mdTimeout, stallCycles
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc
// Purpose: hazard control for a 5-stage pipeline with a slow data memory
// and a multi-cycle MUL/DIV unit. Generates EX forwarding selects,
// load-use stalls of LOAD_USE_BUBBLES cycles, an MD stall handshake with
// a watchdog, branch/jump flushes and a saturating stall-cycle counter.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   hz  - hazard_unit_mc_if slave modport (all datapath signals)
// All stall/flush/forward outputs are combinational from state and
// inputs; only mdTimeout and stallCycles are registered.
module hazard_unit_mc #(
  parameter int ADDR_W           = 5,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int MD_TIMEOUT       = 64,
  parameter int CNT_W            = 16
) (
  input logic             clk,
  input logic             rst,
  hazard_unit_mc_if.slave hz
);

  localparam int WD_W = $clog2(MD_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(MD_TIMEOUT);

  typedef enum logic [1:0] {
    RUN,
    LOAD_STALL,
    MD_WAIT
  } state_t;

  state_t          state;
  logic [1:0]      bubble_cnt;
  logic [WD_W-1:0] watchdog;
  logic            load_use;
  logic            redir;
  logic            md_begin;

  assign load_use = (hz.ResultSrcE == 2'b01) && (hz.RdE != REG_ZERO) &&
                    ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));
  // A redirect is meaningless while the MD op still occupies Execute.
  assign redir    = (hz.PCSrcE != 2'b00) && (state != MD_WAIT);
  // An MD op that finishes in its first cycle never needs to stall.
  assign md_begin = hz.mdStartE && !hz.mdDone;

  // Stall, flush and forward controls. Everything is forced quiet while
  // rst is high so the pipeline registers see clean enables.
  always_comb begin
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.StallE    = 1'b0;
    hz.FlushD    = 1'b0;
    hz.FlushE    = 1'b0;
    hz.FlushM    = 1'b0;
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    if (!rst) begin
      // M stage holds the younger result, so it wins over W.
      if (hz.RegWriteM && (hz.Rs1E == hz.RdM) && (hz.Rs1E != REG_ZERO))
        hz.ForwardAE = 2'b10;
      else if (hz.RegWriteW && (hz.Rs1E == hz.RdW) && (hz.Rs1E != REG_ZERO))
        hz.ForwardAE = 2'b01;
      if (hz.RegWriteM && (hz.Rs2E == hz.RdM) && (hz.Rs2E != REG_ZERO))
        hz.ForwardBE = 2'b10;
      else if (hz.RegWriteW && (hz.Rs2E == hz.RdW) && (hz.Rs2E != REG_ZERO))
        hz.ForwardBE = 2'b01;

      case (state)
        RUN: begin
          if (redir) begin
            hz.FlushD = 1'b1;
            hz.FlushE = 1'b1;
          end else if (load_use) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.FlushE = 1'b1;
          end else if (md_begin) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
            hz.FlushM = 1'b1;
          end
        end
        LOAD_STALL: begin
          hz.StallF = 1'b1;
          hz.StallD = 1'b1;
          hz.FlushE = 1'b1;
        end
        MD_WAIT: begin
          // Stalls release in the very cycle the MD result shows up.
          if (!hz.mdDone) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
            hz.FlushM = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Control FSM, extra load bubbles, MD watchdog and the stall counter.
  // The watchdog counts MD_WAIT cycles starting at 1 on entry and holds
  // at its limit so it can never wrap back under it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      bubble_cnt     <= 2'd0;
      watchdog       <= '0;
      hz.mdTimeout   <= 1'b0;
      hz.stallCycles <= '0;
    end else begin
      if (hz.StallF && (hz.stallCycles != CNT_MAX))
        hz.stallCycles <= hz.stallCycles + CNT_W'(1);

      case (state)
        RUN: begin
          if (!redir && load_use) begin
            if (LOAD_USE_BUBBLES > 1) begin
              state      <= LOAD_STALL;
              bubble_cnt <= 2'(LOAD_USE_BUBBLES - 1);
            end
          end else if (!redir && md_begin) begin
            state    <= MD_WAIT;
            watchdog <= WD_W'(1);
          end
        end
        LOAD_STALL: begin
          bubble_cnt <= bubble_cnt - 2'd1;
          if (bubble_cnt <= 2'd1)
            state <= RUN;
        end
        MD_WAIT: begin
          if (hz.mdDone) begin
            state <= RUN;
          end else begin
            if (watchdog < WD_LIMIT)
              watchdog <= watchdog + WD_W'(1);
            if (watchdog >= WD_LIMIT)
              hz.mdTimeout <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb_hazard_unit_mc
// Purpose: directed, scoreboard-checked bench for hazard_unit_mc. Three
// instances share one stimulus stream:
//   dut 0: LOAD_USE_BUBBLES=1, MD_TIMEOUT=8,  CNT_W=16
//   dut 1: LOAD_USE_BUBBLES=3, MD_TIMEOUT=64, CNT_W=16
//   dut 2: LOAD_USE_BUBBLES=3, MD_TIMEOUT=64, CNT_W=2 (counter saturation)
// Each vector is driven 1 ns after a rising edge and its hand-computed
// expectation is queued; the monitor compares at the following falling
// edge. Outputs are packed as
// {StallF,StallD,StallE,FlushD,FlushE,FlushM,ForwardAE,ForwardBE,mdTimeout}.
module tb_hazard_unit_mc;

  localparam logic [10:0] E0   = 11'b000000_00000;
  localparam logic [10:0] LU   = 11'b110010_00000;
  localparam logic [10:0] MD   = 11'b111001_00000;
  localparam logic [10:0] RD   = 11'b000110_00000;
  localparam logic [10:0] TO   = 11'b000000_00001;
  localparam logic [10:0] FA_M = 11'b000000_10000;
  localparam logic [10:0] FA_W = 11'b000000_01000;
  localparam logic [10:0] FB_M = 11'b000000_00100;
  localparam logic [10:0] FB_W = 11'b000000_00010;
  localparam int ALL  = 3;
  localparam int NONE = -1;

  typedef struct {
    logic       rst;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       regwm, regww;
    logic [1:0] ressrc, pcsrc;
    logic       mdstart, mddone;
  } stim_t;

  typedef struct {
    int          dut;
    string       name;
    logic [10:0] out;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic        regwm, regww;
  logic [1:0]  ressrc, pcsrc;
  logic        mdstart, mddone;
  logic [10:0] outs [3];
  logic [15:0] cnts [3];

  stim_t s;
  exp_t  q [$];
  exp_t  e;
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LUB = (g == 0) ? 1 : 3;
    localparam int MDT = (g == 0) ? 8 : 64;
    localparam int CW  = (g == 2) ? 2 : 16;

    hazard_unit_mc_if #(.ADDR_W(5), .CNT_W(CW)) bus ();

    assign bus.Rs1D       = rs1d;
    assign bus.Rs2D       = rs2d;
    assign bus.Rs1E       = rs1e;
    assign bus.Rs2E       = rs2e;
    assign bus.RdE        = rde;
    assign bus.RdM        = rdm;
    assign bus.RdW        = rdw;
    assign bus.RegWriteM  = regwm;
    assign bus.RegWriteW  = regww;
    assign bus.ResultSrcE = ressrc;
    assign bus.PCSrcE     = pcsrc;
    assign bus.mdStartE   = mdstart;
    assign bus.mdDone     = mddone;

    hazard_unit_mc #(
      .ADDR_W(5),
      .LOAD_USE_BUBBLES(LUB),
      .MD_TIMEOUT(MDT),
      .CNT_W(CW)
    ) dut (
      .clk(clk),
      .rst(rst),
      .hz(bus)
    );

    assign outs[g] = {bus.StallF, bus.StallD, bus.StallE, bus.FlushD,
                      bus.FlushE, bus.FlushM, bus.ForwardAE, bus.ForwardBE,
                      bus.mdTimeout};
    assign cnts[g] = 16'(bus.stallCycles);
  end

  // Single comparison point: bumps the counters the summary reports.
  task automatic checkOutput(input string name, input int dut,
                             input logic [26:0] act, input logic [26:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s dut=%0d actual=%b/%0d required=%b/%0d",
               name, dut, act[26:16], act[15:0], req[26:16], req[15:0]);
    end
  endtask

  task automatic idle();
    s = '{rst: 1'b0, rs1d: 5'd0, rs2d: 5'd0, rs1e: 5'd0, rs2e: 5'd0,
          rde: 5'd0, rdm: 5'd0, rdw: 5'd0, regwm: 1'b0, regww: 1'b0,
          ressrc: 2'b00, pcsrc: 2'b00, mdstart: 1'b0, mddone: 1'b0};
  endtask

  // Drive the staged vector for one cycle and queue what should appear.
  task automatic applyStimulus(input int dut, input string name,
                               input logic [10:0] out, input logic [15:0] cnt);
    exp_t x;
    @(posedge clk);
    #1;
    rst     = s.rst;
    rs1d    = s.rs1d;
    rs2d    = s.rs2d;
    rs1e    = s.rs1e;
    rs2e    = s.rs2e;
    rde     = s.rde;
    rdm     = s.rdm;
    rdw     = s.rdw;
    regwm   = s.regwm;
    regww   = s.regww;
    ressrc  = s.ressrc;
    pcsrc   = s.pcsrc;
    mdstart = s.mdstart;
    mddone  = s.mddone;
    x.name  = name;
    x.out   = out;
    x.cnt   = cnt;
    for (int d = 0; d < 3; d++) begin
      if (dut == ALL || dut == d) begin
        x.dut = d;
        q.push_back(x);
      end
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      checkOutput(e.name, e.dut, {outs[e.dut], cnts[e.dut]}, {e.out, e.cnt});
    end
  end

  initial begin
    rst = 1'b1;
    {rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw} = '0;
    {regwm, regww, ressrc, pcsrc, mdstart, mddone} = '0;

    // Reset: every control quiet even with hazards present on the inputs.
    idle();
    s.rst = 1'b1; s.pcsrc = 2'b01; s.ressrc = 2'b01; s.rde = 5'd7;
    s.rs2d = 5'd7; s.regwm = 1'b1; s.rdm = 5'd5; s.rs1e = 5'd5;
    applyStimulus(ALL, "reset_hold", E0, 16'd0);

    // Forwarding priority on both operands.
    idle(); s.rs1e = 5'd5; s.rdm = 5'd5; s.rdw = 5'd5; s.regwm = 1'b1; s.regww = 1'b1;
    applyStimulus(ALL, "fwdA_mem", FA_M, 16'd0);
    s.regwm = 1'b0;
    applyStimulus(ALL, "fwdA_wb", FA_W, 16'd0);
    s.rs1e = 5'd0;
    applyStimulus(ALL, "fwdA_x0", E0, 16'd0);
    idle(); s.rs2e = 5'd9; s.rdm = 5'd9; s.rdw = 5'd9; s.regwm = 1'b1; s.regww = 1'b1;
    applyStimulus(ALL, "fwdB_mem", FB_M, 16'd0);
    s.rdm = 5'd4;
    applyStimulus(ALL, "fwdB_wb", FB_W, 16'd0);

    // Load-use, one bubble.
    idle(); s.ressrc = 2'b01; s.rde = 5'd7; s.rs2d = 5'd7;
    applyStimulus(0, "lu1_stall", LU, 16'd0);
    idle();
    applyStimulus(0, "lu1_release", E0, 16'd1);
    s.ressrc = 2'b01; s.rde = 5'd0; s.rs1d = 5'd0;
    applyStimulus(0, "load_x0", E0, 16'd1);
    idle(); s.pcsrc = 2'b01; s.ressrc = 2'b01; s.rde = 5'd7; s.rs2d = 5'd7;
    applyStimulus(0, "redir_over_lu", RD, 16'd1);
    idle();
    applyStimulus(0, "after_redir", E0, 16'd1);
    s.ressrc = 2'b01; s.rde = 5'd3; s.rs1d = 5'd3;
    applyStimulus(0, "lu1_rs1", LU, 16'd1);
    idle();
    applyStimulus(0, "lu1_rs1_release", E0, 16'd2);
    s.ressrc = 2'b00; s.rde = 5'd3; s.rs1d = 5'd3;
    applyStimulus(0, "alu_not_load", E0, 16'd2);

    // MD handshake: five stall cycles, release in the mdDone cycle.
    idle(); s.mdstart = 1'b1;
    applyStimulus(0, "md_start", MD, 16'd2);
    idle();
    applyStimulus(0, "md_wait1", MD, 16'd3);
    s.pcsrc = 2'b01;
    applyStimulus(0, "md_wait_pcsrc", MD, 16'd4);
    idle();
    applyStimulus(0, "md_wait3", MD, 16'd5);
    applyStimulus(0, "md_wait4", MD, 16'd6);
    s.mddone = 1'b1;
    applyStimulus(0, "md_done", E0, 16'd7);
    idle();
    applyStimulus(0, "md_after", E0, 16'd7);
    s.mdstart = 1'b1; s.mddone = 1'b1;
    applyStimulus(0, "md_single", E0, 16'd7);
    idle();
    applyStimulus(0, "md_single_after", E0, 16'd7);

    // Watchdog (MD_TIMEOUT=8): flag appears after 8 MD_WAIT cycles.
    s.mdstart = 1'b1;
    applyStimulus(0, "wd_start", MD, 16'd7);
    idle();
    for (int i = 1; i <= 8; i++)
      applyStimulus(0, "wd_wait", MD, 16'(7 + i));
    applyStimulus(0, "wd_timeout", MD | TO, 16'd16);
    applyStimulus(0, "wd_sticky", MD | TO, 16'd17);
    s.rst = 1'b1;
    applyStimulus(0, "wd_rst", TO, 16'd18);
    idle();
    applyStimulus(ALL, "post_rst", E0, 16'd0);

    // Load-use, three bubbles, then reset in the second bubble.
    s.ressrc = 2'b01; s.rde = 5'd7; s.rs2d = 5'd7;
    applyStimulus(1, "lu3_b1", LU, 16'd0);
    idle();
    applyStimulus(1, "lu3_b2", LU, 16'd1);
    applyStimulus(1, "lu3_b3", LU, 16'd2);
    applyStimulus(1, "lu3_done", E0, 16'd3);
    s.ressrc = 2'b01; s.rde = 5'd7; s.rs2d = 5'd7;
    applyStimulus(1, "lu3r_b1", LU, 16'd3);
    s.rst = 1'b1;
    applyStimulus(1, "lu3r_rst", E0, 16'd4);
    idle();
    applyStimulus(1, "lu3r_after", E0, 16'd0);
    applyStimulus(1, "lu3r_run", E0, 16'd0);
    s.ressrc = 2'b01; s.rde = 5'd7; s.rs2d = 5'd7;
    applyStimulus(1, "lu3h_b1", LU, 16'd0);
    applyStimulus(1, "lu3h_b2", LU, 16'd1);
    applyStimulus(1, "lu3h_b3", LU, 16'd2);
    idle();
    applyStimulus(1, "lu3h_done", E0, 16'd3);

    // Counter saturation on the 2-bit instance.
    s.rst = 1'b1;
    applyStimulus(NONE, "sat_rst", E0, 16'd0);
    idle();
    applyStimulus(2, "sat_idle", E0, 16'd0);
    s.mdstart = 1'b1;
    applyStimulus(2, "sat_start", MD, 16'd0);
    idle();
    applyStimulus(2, "sat_w1", MD, 16'd1);
    applyStimulus(2, "sat_w2", MD, 16'd2);
    applyStimulus(2, "sat_w3", MD, 16'd3);
    applyStimulus(2, "sat_w4", MD, 16'd3);
    s.mddone = 1'b1;
    applyStimulus(2, "sat_done", E0, 16'd3);
    idle();
    applyStimulus(2, "sat_hold", E0, 16'd3);

    @(posedge clk);
    @(posedge clk);
    checkOutput("queue_drained", NONE, 27'(q.size()), 27'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
